// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised synchronous sequence detector. Watches a stream of W-bit
// symbols and emits a one-cycle registered pulse on y_o when the last DEPTH
// accepted symbols equal the run-time programmable pattern pat_i. On a
// mismatch, progress falls back to the longest candidate suffix that is still
// a pattern prefix, so partial matches are never lost.
//
// Optional feature macro: SEQDET_COUNT_EN
//   defined   -> saturating match counter is built and drives match_cnt_o
//   undefined -> no counter logic, match_cnt_o tied to 0
//
// Parameters
//   W      symbol width in bits (>=1)
//   DEPTH  pattern length in symbols (>=2)
//   CNT_W  match counter width (>=1)
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset, clears all state
//   en_i         symbol valid; sym_i accepted on a rising edge when high
//   sym_i        input symbol
//   pat_i        pattern; bits [W-1:0] are the first expected symbol
//   overlap_i    1 = overlapping matches, 0 = non-overlapping
//   clr_i        synchronous clear of history, progress, y and counter
//   y_o          registered match pulse
//   progress_o   number of pattern-prefix symbols currently matched
//   match_cnt_o  saturating match count
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [W-1:0]               sym_i,
    input  logic [W*DEPTH-1:0]         pat_i,
    input  logic                       overlap_i,
    input  logic                       clr_i,
    output logic                       y_o,
    output logic [$clog2(DEPTH)-1:0]   progress_o,
    output logic [CNT_W-1:0]           match_cnt_o
);

    localparam int PW = $clog2(DEPTH);

    // History: index DEPTH-2 is the most recent accepted symbol, index 0 the
    // oldest. Only the newest vcnt_q entries are meaningful.
    logic [W-1:0]  hist_q [DEPTH-1];
    logic [W-1:0]  hist_d [DEPTH-1];
    logic [PW-1:0] vcnt_q, vcnt_d;
    logic [PW-1:0] prog_q, prog_d;
    logic          y_q, y_d;

    logic [W-1:0]  cand [DEPTH];     // valid history followed by sym_i
    logic [DEPTH:1] suf_ok;          // suf_ok[k]: last k candidate symbols == pat[0..k-1]
    logic          accept;
    logic          match;
    logic [PW-1:0] fallback;

    assign accept = en_i & ~clr_i;

    generate
        for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_cand
            assign cand[gi] = hist_q[gi];
        end
    endgenerate
    assign cand[DEPTH-1] = sym_i;

    // A suffix of length k may only be considered when it lies entirely within
    // valid history plus the new symbol; stale entries are never compared.
    generate
        for (genvar gk = 1; gk <= DEPTH; gk++) begin : g_suf
            logic [gk-1:0] eq;
            for (genvar gj = 0; gj < gk; gj++) begin : g_eq
                assign eq[gj] = (cand[DEPTH-gk+gj] == pat_i[gj*W +: W]);
            end
            assign suf_ok[gk] = (&eq) && ((int'(vcnt_q) + 1) >= gk);
        end
    endgenerate

    assign match = suf_ok[DEPTH];

    // Longest proper suffix that is also a pattern prefix (ascending scan, so
    // the last hit wins).
    always_comb begin
        fallback = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (suf_ok[k]) begin
                fallback = PW'(k);
            end
        end
    end

    // Next-state logic
    always_comb begin
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        prog_d = prog_q;
        y_d    = 1'b0;
        if (clr_i) begin
            vcnt_d = '0;
            prog_d = '0;
        end else if (en_i) begin
            for (int i = 0; i < DEPTH - 2; i++) begin
                hist_d[i] = hist_q[i+1];
            end
            hist_d[DEPTH-2] = sym_i;
            vcnt_d = (vcnt_q == PW'(DEPTH - 1)) ? vcnt_q : vcnt_q + 1'b1;
            y_d    = match;
            if (match && !overlap_i) begin
                // Non-overlapping: the next match needs DEPTH fresh symbols
                vcnt_d = '0;
                prog_d = '0;
            end else begin
                prog_d = fallback;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                hist_q[i] <= '0;
            end
            vcnt_q <= '0;
            prog_q <= '0;
            y_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            vcnt_q <= vcnt_d;
            prog_q <= prog_d;
            y_q    <= y_d;
        end
    end

    // Outputs (all registered)
    assign y_o        = y_q;
    assign progress_o = prog_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (accept && match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt_o = cnt_q;
`else
    assign match_cnt_o = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised synchronous sequence detector, the next generation of the team's two-input Moore pattern FSMs. It watches a stream of W-bit symbols and pulses `y` when the last DEPTH accepted symbols equal a run-time programmable pattern. Overlapping and non-overlapping match modes are selectable at run time, and an optional saturating match counter can be compiled in. It sits between input-conditioning logic and control FSMs that need "sequence seen" events.

## Interface
- `W`, 2: symbol width in bits (≥1).
- `DEPTH`, 4: pattern length in symbols (≥2).
- `CNT_W`, 8: match counter width (≥1).
- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: reset, asynchronous, active-low; clears all state.
- `en`  in  1: symbol valid; `sym` is accepted on a rising `Clk` edge when high.
- `sym`  in  W: input symbol.
- `pat`  in  W*DEPTH: pattern; bits [W-1:0] are the first expected symbol, and the top W bits are the last. Must be held stable while `en` is high.
- `overlap`  in  1: 1 = overlapping matches, 0 = non-overlapping.
- `clr`  in  1: synchronous clear of history, progress and `y`.
- `y`  out  1: registered match pulse.
- `progress`  out  $clog2(DEPTH): number of pattern prefix symbols currently matched (0..DEPTH-1).
- `match_cnt`  out  CNT_W: saturating count of matches.

## Operation
- State: history `hist` holds the last DEPTH-1 accepted symbols, plus a valid count `vcnt` (0..DEPTH-1). `progress` is a registered copy of this state.
- On each accepting edge (`en`=1, `clr`=0), form the candidate sequence: the valid history followed by `sym`.
- Match: the candidate has DEPTH symbols and all of them equal `pat` in order. On a match, `y` is 1 for the next cycle and `match_cnt` increments, saturating at 2^CNT_W-1.
- Non-match: the new `progress` is the largest k ≤ min(`vcnt`+1, DEPTH-1) such that the last k candidate symbols equal `pat` symbols 0..k-1. This is a full prefix-suffix fallback, not a simple reset to 0.
- After a match with `overlap`=1: `progress` is the largest proper k < DEPTH whose candidate suffix equals the pattern prefix. The history is kept.
- After a match with `overlap`=0: `progress` becomes 0 and `vcnt` becomes 0. The next match needs DEPTH fresh symbols.
- `en`=0: all state holds, and `y` is 0 the following cycle.
- `clr`=1: `progress`, `vcnt` and `y` go to 0 at the next edge. `match_cnt` also goes to 0. `clr` has priority over `en`; a symbol offered in the same cycle is discarded.
- `Rst`=0 at any time, including mid-sequence: immediately, without waiting for a clock edge, `y`=0, `progress`=0, `match_cnt`=0 and `vcnt`=0. History contents are don't-care.
- Symbols beyond `vcnt` are never compared, so stale history cannot cause false matches.

## Timing
- Latency: the match is decided at the edge that accepts the last symbol. `y` is high for exactly the one cycle following that edge.
- Back-to-back matches (`overlap`=1 with a self-overlapping pattern, e.g. all-equal symbols) give `y` high on consecutive cycles.
- `progress` and `match_cnt` update on the same edge as `y`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Changing `overlap` takes effect on the next accepting edge.
- Changing `pat` mid-stream is legal: comparisons always use the current `pat`, but the current `progress` is not recomputed until the next accepting edge.

## Configuration
- `SEQDET_COUNT_EN` defined: the `match_cnt` register and saturating incrementer are built as described above.
- `SEQDET_COUNT_EN` undefined: no counter logic is built, and `match_cnt` is tied to 0. `clr` and `Rst` behaviour for all other state is unchanged.

## Test plan
- Overlapping matches. Setup: W=2, DEPTH=4, pat = 1,2,1,2 (first to last), `overlap`=1. Stimulus: stream 1,2,1,2,1,2 with `en` held high. Expected: `y` pulses after the 4th and 6th symbols; `progress` reads 1,2,3,2,3,2; `match_cnt`=2.
- Non-overlapping matches. Same stream with `overlap`=0. Expected: a single `y` pulse after the 4th symbol; `progress` returns to 0 and then reads 1,2; `match_cnt`=1.
- Prefix fallback and gaps. Pattern 1,1,2,3, stream 1,1,1,2,3, with `en` low for 2 cycles between symbols 3 and 4. Expected: `progress` reads 1,2,2,3 and holds during the gap; `y` pulses once after the last symbol.
- Counter saturation. CNT_W=2, `SEQDET_COUNT_EN` defined, 5 matches. Expected: `match_cnt` reads 1,2,3,3,3. With the macro undefined, `match_cnt` stays 0 throughout.
- `clr` priority. Assert `clr` in the same cycle as the final matching symbol. Expected: no `y` pulse; `progress`=0 and `match_cnt`=0 on the next cycle.
- Asynchronous reset. Drop `Rst` mid-cycle when `progress`=3. Expected: all outputs go to 0 before the next `Clk` edge. After `Rst` is released, a full DEPTH-symbol pattern is required to produce a `y` pulse.
